// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM window sequencer slice.
package lstm_pkg;

  localparam int WIDTH = 18;
  localparam int FRAC  = 11;

  typedef logic signed [WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUT    = 2'd3
  } state_e;

  // 1.0 in Q6.11
  localparam sample_t ONE = 18'sd2048;

endpackage

// File: rtl/lstm_window_sequencer_if.sv
// Sample-in and result-out streams of the LSTM window sequencer.
// Both streams: a beat transfers on a rising edge where valid & ready; the source holds data stable while valid & !ready.
interface lstm_window_sequencer_if #(
  parameter int WIDTH = 18,
  parameter int SEQ_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_h;
  logic [WIDTH-1:0] m_c;
  logic [SEQ_W-1:0] m_seq;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_h, m_c, m_seq
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_h, m_c, m_seq
  );
endinterface

// File: rtl/lstm_sample_window.sv
// Four-deep sample shift register; w0 oldest, w3 newest, with a count saturating at 4.
module lstm_sample_window #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] w0,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] w3,
  output logic [2:0]       cnt,
  output logic             full
);

  assign full = (cnt == 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0  <= '0;
      w1  <= '0;
      w2  <= '0;
      w3  <= '0;
      cnt <= 3'd0;
    end else if (clear) begin
      // stale words stay in place; four fresh shifts overwrite them before the next run
      cnt <= 3'd0;
    end else if (shift) begin
      w0 <= w1;
      w1 <= w2;
      w2 <= w3;
      w3 <= din;
      if (!full) cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/lstm_window_sequencer.sv
// Front-end sequencer: keeps a 4-sample sliding window, issues one LSTM engine run per new full window,
// and forwards the captured (h, c) result downstream with a sequence tag.
module lstm_window_sequencer
  import lstm_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int TIMEOUT = 16,
  parameter int SEQ_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   err_clr,
  lstm_window_sequencer_if.slave bus,
  output logic                   lstm_start,
  output logic [WIDTH-1:0]       lstm_x1,
  output logic [WIDTH-1:0]       lstm_x2,
  output logic [WIDTH-1:0]       lstm_x3,
  output logic [WIDTH-1:0]       lstm_x4,
  input  logic                   lstm_done,
  input  logic [WIDTH-1:0]       lstm_c,
  input  logic [WIDTH-1:0]       lstm_h,
  output logic                   err,
  output logic [1:0]             dbg_state
);

  localparam logic [1:0] ST_ACCEPT = ACCEPT;
  localparam logic [1:0] ST_ISSUE  = ISSUE;
  localparam logic [1:0] ST_WAIT   = WAIT;
  localparam logic [1:0] ST_OUT    = OUT;
  localparam int         TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic [2:0]       cnt;
  logic             full;
  logic             accept;
  logic             timeout_hit;
  logic             m_valid_q;
  logic [WIDTH-1:0] m_h_q;
  logic [WIDTH-1:0] m_c_q;
  logic [SEQ_W-1:0] m_seq_q;

  assign bus.s_ready = (state == ST_ACCEPT);
  assign bus.m_valid = m_valid_q;
  assign bus.m_h     = m_h_q;
  assign bus.m_c     = m_c_q;
  assign bus.m_seq   = m_seq_q;
  assign dbg_state   = state;

  assign accept      = (state == ST_ACCEPT) && bus.s_valid && !flush;
  assign timeout_hit = !flush && (state == ST_WAIT) && !lstm_done && (timer == TW'(TIMEOUT - 1));

  lstm_sample_window #(.WIDTH(WIDTH)) u_window (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .shift (accept),
    .din   (bus.s_data),
    .w0    (lstm_x1),
    .w1    (lstm_x2),
    .w2    (lstm_x3),
    .w3    (lstm_x4),
    .cnt   (cnt),
    .full  (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACCEPT;
      timer      <= '0;
      lstm_start <= 1'b0;
      m_valid_q  <= 1'b0;
      m_h_q      <= '0;
      m_c_q      <= '0;
      m_seq_q    <= '0;
      err        <= 1'b0;
    end else begin
      // a timeout in the same cycle as err_clr wins
      err <= timeout_hit | (err & ~err_clr);
      if (flush) begin
        state      <= ST_ACCEPT;
        lstm_start <= 1'b0;
        m_valid_q  <= 1'b0;
      end else begin
        lstm_start <= 1'b0;
        case (state)
          ST_ACCEPT: begin
            // the accepted sample fills the window when it is already at 3 or saturated at 4
            if (accept && (full || cnt == 3'd3)) begin
              state      <= ST_ISSUE;
              lstm_start <= 1'b1;
            end
          end
          ST_ISSUE: begin
            timer <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            timer <= timer + 1'b1;
            if (lstm_done) begin
              m_h_q     <= lstm_h;
              m_c_q     <= lstm_c;
              m_valid_q <= 1'b1;
              state     <= ST_OUT;
            end else if (timeout_hit) begin
              state <= ST_ACCEPT;
            end
          end
          ST_OUT: begin
            if (bus.m_ready) begin
              m_valid_q <= 1'b0;
              m_seq_q   <= m_seq_q + 1'b1;
              state     <= ST_ACCEPT;
            end
          end
          default: state <= ST_ACCEPT;
        endcase
      end
    end
  end

endmodule
